// File: rtl/counter_pkg.sv
// Shared definitions for the modulo-N counter: output encodings and the
// wrap-aware next-count rule.
package counter_pkg;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  // Evaluated in 32 bits, which is wider than any legal WIDTH.
  // A full-range counter (MODULUS = 2^WIDTH) therefore cannot overflow before the wrap compare.
  function automatic int unsigned next_count(input int unsigned cnt,
                                             input logic        up,
                                             input int unsigned modulus);
    if (up) return (cnt + 1 == modulus) ? 0 : cnt + 1;
    else    return (cnt == 0) ? modulus - 1 : cnt - 1;
  endfunction

endpackage

// File: rtl/gray_encode.sv
// Combinational binary-to-Gray converter.
module gray_encode #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/counter_mod_n.sv
// Modulo-N up/down counter with load, enable, binary/Gray registered output
// and terminal-count / carry outputs for cascading.
module counter_mod_n
  import counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             MODE,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CO
);

  localparam longint unsigned RANGE   = 64'd1 << WIDTH;
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  if (WIDTH < 2 || MODULUS < 2 || longint'(MODULUS) > longint'(RANGE)) begin : g_bad_params
    $fatal(1, "counter_mod_n: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] gray_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    // NOTE: default first so every path assigns cnt_next and no latch is inferred.
    cnt_next = cnt;
    if (LOAD) begin
      cnt_next = (D > MAX_CNT) ? MAX_CNT : D;
    end else if (EN) begin
      cnt_next = WIDTH'(next_count(int'(unsigned'(cnt)), UP, MODULUS));
    end
  end

  gray_encode #(.WIDTH(WIDTH)) u_gray (
    .bin  (cnt_next),
    .gray (gray_next)
  );

  assign q_next = (MODE == MODE_GRAY) ? gray_next : cnt_next;

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments for registered state; reset is synchronous.
    if (!RST_N) begin
      cnt <= '0;
      Q   <= '0;
    end else begin
      cnt <= cnt_next;
      Q   <= q_next;
    end
  end

  assign TC = UP ? (cnt == MAX_CNT) : (cnt == '0);
  assign CO = TC & EN;

endmodule

// File: tb/tb_counter_mod_n.sv
// Bench for counter_mod_n: an arithmetic reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_counter_mod_n;

  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic       mode;
    logic [3:0] d;
  } ctl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  ctl_t ca, cb, cc;

  logic [2:0] qa, qb;
  logic [3:0] q0, q1;
  logic tca, coa, tcb, cob, tc0, co0, tc1, co1;

  counter_mod_n #(.WIDTH(3), .MODULUS(8)) dut_a (
    .CLK(clk), .RST_N(ca.rst_n), .EN(ca.en), .UP(ca.up), .LOAD(ca.load),
    .D(ca.d[2:0]), .MODE(ca.mode), .Q(qa), .TC(tca), .CO(coa));

  counter_mod_n #(.WIDTH(3), .MODULUS(6)) dut_b (
    .CLK(clk), .RST_N(cb.rst_n), .EN(cb.en), .UP(cb.up), .LOAD(cb.load),
    .D(cb.d[2:0]), .MODE(cb.mode), .Q(qb), .TC(tcb), .CO(cob));

  counter_mod_n #(.WIDTH(4), .MODULUS(10)) dut_c0 (
    .CLK(clk), .RST_N(cc.rst_n), .EN(cc.en), .UP(1'b1), .LOAD(1'b0),
    .D(4'd0), .MODE(1'b0), .Q(q0), .TC(tc0), .CO(co0));

  counter_mod_n #(.WIDTH(4), .MODULUS(10)) dut_c1 (
    .CLK(clk), .RST_N(cc.rst_n), .EN(co0), .UP(1'b1), .LOAD(1'b0),
    .D(4'd0), .MODE(1'b0), .Q(q1), .TC(tc1), .CO(co1));

  int n_checks = 0;
  int n_errors = 0;
  bit check_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts as plain integers in 0..m-1.
  function automatic int mdl_next(int c, bit rst_n, bit load, bit en, bit up, int d, int m);
    if (!rst_n)    return 0;
    else if (load) return (d < m) ? d : m - 1;
    else if (en)   return up ? (c + 1) % m : (c + m - 1) % m;
    else           return c;
  endfunction

  function automatic int mdl_q(int c, bit mode);
    return mode ? (c ^ (c >> 1)) : c;
  endfunction

  function automatic bit mdl_tc(int c, bit up, int m);
    return up ? (c == m - 1) : (c == 0);
  endfunction

  int ma = 0, mb = 0, m0 = 0, m1 = 0;
  int qa_m = 0, qb_m = 0, q0_m = 0, q1_m = 0;

  always @(posedge clk) begin
    bit carry0;
    carry0 = mdl_tc(m0, 1'b1, 10) & cc.en;
    ma = mdl_next(ma, ca.rst_n, ca.load, ca.en, ca.up, int'(ca.d[2:0]), 8);
    mb = mdl_next(mb, cb.rst_n, cb.load, cb.en, cb.up, int'(cb.d[2:0]), 6);
    m0 = mdl_next(m0, cc.rst_n, 1'b0, cc.en, 1'b1, 0, 10);
    m1 = mdl_next(m1, cc.rst_n, 1'b0, carry0, 1'b1, 0, 10);
    qa_m = ca.rst_n ? mdl_q(ma, ca.mode) : 0;
    qb_m = cb.rst_n ? mdl_q(mb, cb.mode) : 0;
    q0_m = m0;
    q1_m = m1;
  end

  always @(negedge clk) begin
    if (check_on) begin
      bit t0;
      t0 = mdl_tc(m0, 1'b1, 10);
      check("a_q",  32'(qa),  32'(qa_m));
      check("a_tc", 32'(tca), 32'(mdl_tc(ma, ca.up, 8)));
      check("a_co", 32'(coa), 32'(mdl_tc(ma, ca.up, 8) & ca.en));
      check("b_q",  32'(qb),  32'(qb_m));
      check("b_tc", 32'(tcb), 32'(mdl_tc(mb, cb.up, 6)));
      check("b_co", 32'(cob), 32'(mdl_tc(mb, cb.up, 6) & cb.en));
      check("c0_q", 32'(q0),  32'(q0_m));
      check("c0_co", 32'(co0), 32'(t0 & cc.en));
      check("c1_q", 32'(q1),  32'(q1_m));
      check("c1_co", 32'(co1), 32'(mdl_tc(m1, 1'b1, 10) & t0 & cc.en));
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_b_up[7]    = '{1, 2, 3, 4, 5, 0, 1};
    int exp_b_down[6]  = '{4, 3, 2, 1, 0, 5};
    int exp_gray[8]    = '{1, 3, 2, 6, 7, 5, 4, 0};
    logic [2:0] prev;

    ca = '{rst_n: 1'b0, en: 1'b0, up: 1'b1, load: 1'b0, mode: 1'b0, d: 4'd0};
    cb = ca;
    cc = ca;
    edges(2);
    ca.rst_n = 1'b1; cb.rst_n = 1'b1; cc.rst_n = 1'b1;
    check_on = 1'b1;
    check("reset_a_q", 32'(qa), 32'd0);
    check("reset_a_tc", 32'(tca), 32'd0);

    // Count to 5, then reset with a competing load.
    ca.en = 1'b1;
    edges(5);
    check("a_count5", 32'(qa), 32'd5);
    ca.rst_n = 1'b0; ca.load = 1'b1; ca.d = 4'd3;
    edges(1);
    check("a_rst_over_load_q", 32'(qa), 32'd0);
    check("a_rst_over_load_tc", 32'(tca), 32'd0);
    ca.rst_n = 1'b1; ca.load = 1'b0; ca.en = 1'b0;
    edges(1);

    // Gray sequence, one bit changing per edge.
    ca.mode = 1'b1; ca.en = 1'b1;
    prev = qa;
    for (int i = 0; i < 8; i++) begin
      edges(1);
      check("a_gray_q", 32'(qa), 32'(exp_gray[i]));
      check("a_gray_onebit", 32'($countones(prev ^ qa)), 32'd1);
      prev = qa;
    end
    ca.mode = 1'b0; ca.en = 1'b0;

    // Load beats count at terminal count; carry still visible before the edge.
    ca.load = 1'b1; ca.d = 4'd7;
    edges(1);
    check("a_load7", 32'(qa), 32'd7);
    ca.d = 4'd2; ca.en = 1'b1;
    #1;
    check("a_co_before_load", 32'(coa), 32'd1);
    edges(1);
    check("a_load_priority", 32'(qa), 32'd2);
    ca.load = 1'b0; ca.en = 1'b0;

    // Modulo-6 up wrap.
    cb.en = 1'b1; cb.up = 1'b1;
    for (int i = 0; i < 7; i++) begin
      edges(1);
      check("b_up_q", 32'(qb), 32'(exp_b_up[i]));
      check("b_up_tc", 32'(tcb), 32'(exp_b_up[i] == 5));
    end
    cb.en = 1'b0;

    // Load clamp, then down wrap.
    cb.load = 1'b1; cb.d = 4'd7;
    edges(1);
    check("b_clamp", 32'(qb), 32'd5);
    cb.load = 1'b0; cb.up = 1'b0; cb.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      edges(1);
      check("b_down_q", 32'(qb), 32'(exp_b_down[i]));
      check("b_down_tc", 32'(tcb), 32'(exp_b_down[i] == 0));
    end

    // Direction reversal at the top of the range.
    cb.up = 1'b1;
    #1;
    check("b_tc_up_at_max", 32'(tcb), 32'd1);
    cb.up = 1'b0;
    #1;
    check("b_tc_drops", 32'(tcb), 32'd0);
    edges(1);
    check("b_reverse_dec", 32'(qb), 32'd4);

    // Mode change while holding re-encodes without moving the count.
    cb.en = 1'b0; cb.mode = 1'b1;
    edges(1);
    check("b_reencode_gray", 32'(qb), 32'd6);
    cb.mode = 1'b0;
    edges(1);
    check("b_reencode_bin", 32'(qb), 32'd4);

    // Two-digit decimal cascade.
    cc.rst_n = 1'b0;
    edges(1);
    cc.rst_n = 1'b1; cc.en = 1'b1;
    edges(25);
    check("cascade_q1", 32'(q1), 32'd2);
    check("cascade_q0", 32'(q0), 32'd5);
    cc.en = 1'b0;
    edges(2);

    check_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
